// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: control inputs, IM port and IF/ID delivery grouped in one bundle.
//  master : fetch_ctrl side (drives im_addr, if_*, halted, fetch_count)
//  slave  : environment side (drives start, stall, redirect, redirect_addr, instr_in)
interface fetch_ctrl_if;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] instr_in;
  logic [31:0] im_addr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  start, stall, redirect, redirect_addr, instr_in,
    output im_addr, if_instr, if_pc, if_valid, halted, fetch_count
  );

  modport slave (
    output start, stall, redirect, redirect_addr, instr_in,
    input  im_addr, if_instr, if_pc, if_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, addresses the combinational IM, delivers
// instruction/PC/valid to IF/ID, applies stall and redirect, drains and parks on halt.
// Ports:
//  clk  - clock, rising edge
//  rst  - synchronous active-high reset
//  fb   - fetch bus (master side): start/stall/redirect/redirect_addr/instr_in in;
//         im_addr/if_instr/if_pc/if_valid/halted/fetch_count out
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] INIT_ADDR    = 32'hFFFF_FFFC,
  parameter int unsigned IMEM_DEPTH   = 128,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master fb
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [31:0]          count_q, count_d;

  logic        in_range_c;
  logic        is_halt_c;
  logic        if_valid_c;
  logic [31:0] redirect_pc_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= INIT_ADDR;
      drain_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      count_q <= count_d;
    end
  end

  // Next-state and fetch-valid decode; redirect beats stall beats halt/out-of-range
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_d       = drain_q;
    count_d       = count_q;
    if_valid_c    = 1'b0;
    in_range_c    = (pc_q >> 2) < 32'(IMEM_DEPTH);
    is_halt_c     = (fb.instr_in[31:26] == HALT_OPCODE);
    redirect_pc_c = fb.redirect_addr & 32'hFFFF_FFFC;

    case (state_q)
      S_IDLE: begin
        if (fb.start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_RUN: begin
        if_valid_c = in_range_c & ~is_halt_c & ~fb.redirect;
        if (fb.redirect) begin
          pc_d = redirect_pc_c;
        end else if (fb.stall) begin
          pc_d = pc_q;
        end else if (!in_range_c || is_halt_c) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
        end else begin
          pc_d    = pc_q + 32'd4;
          count_d = count_q + 32'd1;
        end
      end
      S_DRAIN: begin
        // A redirect here means the halt itself was on the wrong path
        if (fb.redirect) begin
          state_d = S_RUN;
          pc_d    = redirect_pc_c;
        end else if (drain_q == '0) begin
          state_d = S_HALTED;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // im_addr comes straight from the PC register, so stall/redirect never reach it combinationally
  assign fb.im_addr     = pc_q;
  assign fb.if_pc       = pc_q;
  assign fb.if_valid    = if_valid_c;
  assign fb.if_instr    = if_valid_c ? fb.instr_in : 32'h0000_0000;
  assign fb.halted      = (state_q == S_HALTED);
  assign fb.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] INIT_ADDR  = 32'hFFFF_FFFC;
  localparam int          DEPTH      = 128;
  localparam int          DRAIN      = 4;
  localparam logic [31:0] HALT_WORD  = 32'hFC00_0000;
  localparam logic [31:0] ADD_WORD   = 32'h0022_0820;
  localparam logic [31:0] SUB_WORD   = 32'h0022_0822;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .fb  (bus.master)
  );

  logic [31:0] imem [DEPTH];

  // Combinational instruction memory; anything outside the array reads as halt
  always_comb begin
    if ((bus.im_addr >> 2) < 32'(DEPTH)) bus.instr_in = imem[bus.im_addr[8:2]];
    else                                 bus.instr_in = HALT_WORD;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: PC, consumed count and a coarse view of what fetch is doing
  logic [31:0] m_pc;
  logic [31:0] m_count;
  bit          m_known    = 1'b0;
  bit          m_fetching = 1'b0;
  bit          m_halted   = 1'b0;
  int          m_drain_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] im_word(input logic [31:0] a);
    if (a < 32'(DEPTH * 4)) return imem[a[8:2]];
    return HALT_WORD;
  endfunction

  // One clock: drive inputs, check outputs at negedge, then advance the model at posedge
  task automatic cyc(input bit r, input bit st, input bit sl, input bit rd, input logic [31:0] ra);
    bit          inr, hlt, v;
    logic [31:0] w;
    rst                = r;
    bus.start          = st;
    bus.stall          = sl;
    bus.redirect       = rd;
    bus.redirect_addr  = ra;
    @(negedge clk);
    w   = im_word(m_pc);
    inr = (m_pc < 32'(DEPTH * 4));
    hlt = (w[31:26] == 6'h3F);
    v   = m_fetching && inr && !hlt && !rd;
    if (m_known) begin
      chk("im_addr", bus.im_addr, m_pc);
      chk("if_pc", bus.if_pc, m_pc);
      chk("if_valid", 32'(bus.if_valid), 32'(v));
      chk("if_instr", bus.if_instr, v ? w : 32'h0);
      chk("halted", 32'(bus.halted), 32'(m_halted));
      chk("fetch_count", bus.fetch_count, m_count);
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1; m_pc = INIT_ADDR; m_count = 0;
      m_fetching = 1'b0; m_halted = 1'b0; m_drain_left = 0;
    end else if (m_halted) begin
      // parked until reset
    end else if (m_drain_left > 0) begin
      if (rd) begin
        m_drain_left = 0; m_fetching = 1'b1; m_pc = ra & ~32'h3;
      end else begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1'b1;
      end
    end else if (m_fetching) begin
      if (rd) m_pc = ra & ~32'h3;
      else if (sl) begin end
      else if (!inr || hlt) begin
        m_fetching = 1'b0; m_drain_left = DRAIN;
      end else begin
        m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
      end
    end else if (st) begin
      m_fetching = 1'b1; m_pc = RESET_PC;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h0);
  endtask

  task automatic fill_nonhalt();
    for (int i = 0; i < DEPTH; i++) imem[i] = (i % 2 == 0) ? ADD_WORD : SUB_WORD;
  endtask

  initial begin
    bus.start = 0; bus.stall = 0; bus.redirect = 0; bus.redirect_addr = 0;
    fill_nonhalt();

    // 1: add, sub, halt -> drain then halted
    imem[2] = HALT_WORD;
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    chk("t1_reset_addr", bus.im_addr, INIT_ADDR);
    chk("t1_reset_valid", 32'(bus.if_valid), 32'h0);
    cyc(0, 1, 0, 0, 0);
    idle(3 + DRAIN);
    chk("t1_halted", 32'(bus.halted), 32'h1);
    chk("t1_count", bus.fetch_count, 32'd2);
    idle(3);

    // 2: stall three cycles at pc 0x4
    fill_nonhalt();
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    chk("t2_hold_addr", bus.im_addr, 32'h4);
    chk("t2_hold_count", bus.fetch_count, 32'd1);
    idle(1);
    chk("t2_release", bus.im_addr, 32'h8);

    // 3: redirect beats stall at pc 0x10, target bits [1:0] cleared
    idle(2);
    chk("t3_pc", bus.im_addr, 32'h10);
    cyc(0, 0, 1, 1, 32'h23);
    chk("t3_target", bus.im_addr, 32'h20);
    idle(2);

    // 4: redirect during 2nd drain cycle cancels the halt
    imem[2] = HALT_WORD;
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    idle(3);
    idle(1);
    cyc(0, 0, 0, 1, 32'h40);
    chk("t4_target", bus.im_addr, 32'h40);
    chk("t4_not_halted", 32'(bus.halted), 32'h0);
    idle(3);

    // 5: run off the end of the IM
    fill_nonhalt();
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    idle(DEPTH);
    chk("t5_edge_pc", bus.im_addr, 32'h200);
    chk("t5_edge_valid", 32'(bus.if_valid), 32'h0);
    idle(1 + DRAIN - 1);
    chk("t5_not_yet", 32'(bus.halted), 32'h0);
    idle(1);
    chk("t5_halted", 32'(bus.halted), 32'h1);
    chk("t5_count", bus.fetch_count, 32'd128);

    // 6: reset mid-RUN and from HALTED
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0, 0);
    chk("t6_run_addr", bus.im_addr, INIT_ADDR);
    chk("t6_run_count", bus.fetch_count, 32'd0);
    imem[1] = HALT_WORD;
    cyc(0, 1, 0, 0, 0);
    idle(2 + DRAIN + 2);
    chk("t6_parked", 32'(bus.halted), 32'h1);
    cyc(0, 1, 1, 1, 32'h10);
    cyc(1, 0, 0, 0, 0);
    chk("t6_halt_addr", bus.im_addr, INIT_ADDR);
    chk("t6_halt_flag", 32'(bus.halted), 32'h0);

    // Random phase against the model
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 39) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31] = 1'b0;
      imem[i] = w;
    end
    for (int i = 0; i < 3000; i++) begin
      bit r, st, sl, rd;
      r  = ($urandom_range(0, 79) == 0);
      st = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 9) == 0);
      cyc(r, st, sl, rd, 32'($urandom_range(0, 32'h220)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
